udp_tx_arbiter: RTL and testbench
=================================

# udp_tx_arbiter

Two-client transmit arbiter and sequencer for the UDP/IP protocol stack application TX port, running in the `udp_clk` domain. It sits between the application TX sources and the stack's `app_tx_*` interface. Channel 0 is the video `udp_emitter`; channel 1 is a control/status responder. It picks one pending client, runs the stack request/ack handshake, and counts the granted client's payload bytes through a byte mux. It then enforces an inter-packet gap before the next grant.

## Interface
Parameters:
- `ACK_TIMEOUT`, default 4096: `udp_clk` cycles to wait in REQ for `udp2app_tx_ack` before aborting.
- `GAP_CYCLES`, default 16: idle cycles forced after each packet or abort.
- `MAX_LEN`, default 1472: largest legal payload length in bytes.

Ports:
- `udp_clk` in 1: single clock, which is the stack TX clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `cl_req` in 2: per-channel packet request, level, held until `cl_done` or `cl_err`.
- `cl_len0`, `cl_len1` in 16 each: payload length in bytes, sampled at grant.
- `cl_port0`, `cl_port1` in 16 each: destination UDP port, sampled at grant.
- `cl_data0`, `cl_data1` in 8 each: payload byte.
- `cl_valid` in 2: per-channel byte valid.
- `cl_gnt` out 2: one-hot, high for the whole DATA phase of the winner.
- `cl_done` out 2: one-cycle pulse after the last byte.
- `cl_err` out 2: one-cycle pulse on timeout, length 0, or length > `MAX_LEN`.
- `udp2app_tx_ready` in 1: stack idle.
- `udp2app_tx_ack` in 1: stack accepts the request.
- `app_tx_request` out 1: request to the stack.
- `app_tx_data_valid` out 1: byte valid to the stack.
- `app_tx_data` out 8: byte to the stack.
- `app_tx_data_length` out 16: latched length.
- `app_tx_dst_port` out 16: latched port.

## Operation
States are IDLE, REQ, DATA and GAP.

- **IDLE:** when `udp2app_tx_ready` = 1 and `cl_req` ≠ 0, the arbiter selects a winner and latches its length and port.
  - If the length is 0 or greater than `MAX_LEN`, it pulses `cl_err[w]` and goes to GAP. No request reaches the stack.
  - Otherwise it goes to REQ.
- **REQ:** `app_tx_request` = 1, with the ack-timeout counter running.
  - On `udp2app_tx_ack` = 1, it drops the request, clears the byte counter and goes to DATA.
  - If the counter reaches `ACK_TIMEOUT`-1 first, it pulses `cl_err[w]` and goes to GAP.
- **DATA:** `cl_gnt[w]` = 1.
  - `app_tx_data_valid` = `cl_valid[w]`, and `app_tx_data` = `cl_data[w]` combinationally.
  - The 16-bit byte counter increments on each valid byte.
  - The valid byte seen while the count equals len−1 is the last one. On it, the arbiter pulses `cl_done[w]` in the following cycle and goes to GAP.
  - `cl_valid` from the non-granted channel is ignored.
- **GAP:** counts `GAP_CYCLES` cycles, then returns to IDLE.
- The winner is recorded as `last` at grant time, including grants that end in error.

## Timing
- **Reset values:** `app_tx_request`, `app_tx_data_valid`, `cl_gnt`, `cl_done` and `cl_err` = 0. `app_tx_data`, `app_tx_data_length` and `app_tx_dst_port` = 0. State = IDLE, `last` = 1, all counters = 0.
- **Latency:**
  - `cl_req` rises to `app_tx_request` = 1 in 1 cycle, given the stack is ready and the arbiter is in IDLE.
  - `udp2app_tx_ack` to `cl_gnt` = 1 is 1 cycle.
  - The last byte to `cl_done` is 1 cycle.
- **Simultaneous requests:** resolved by the selection rule in Configuration.
- **Ready timing:** `udp2app_tx_ready` is sampled only in IDLE. Its deassertion in any other state is ignored.
- **Request dropped mid-DATA:** if `cl_req[w]` falls during DATA, the packet continues. The arbiter keeps waiting for the remaining bytes; the client owns its length contract.
- **Ack during GAP/IDLE:** ignored.
- **Asynchronous reset mid-packet:** all outputs go to their reset values immediately and no `cl_done` is pulsed. The stack recovers through its own reset.
- **Counter widths:** byte counter 16 bits. Timeout and gap counters are sized `$clog2` of their parameter plus 1.

## Configuration
- **`UDP_TX_ARB_RR_EN` defined:** round-robin selection. When both channels request, the channel ≠ `last` wins.
- **Not defined:** fixed priority, where channel 0 (video) always wins. `last` is still tracked but is unused.

## Structure
- **Package `udp_tx_arb_pkg`:** state enum (IDLE/REQ/DATA/GAP), channel index constants `CH_VIDEO` = 0 and `CH_CTRL` = 1, and the default values of `MAX_LEN`, `ACK_TIMEOUT` and `GAP_CYCLES`.
- **Sub-module `udp_tx_arb_pick`:** combinational winner select from `cl_req` and `last`, with the `UDP_TX_ARB_RR_EN` switch inside it.
- **Top level:** FSM, counters, latches and the byte mux.

## Test plan
- **Single video packet:**
  - Stimulus: `cl_req` = 01, len = 4, port 8080; ack 3 cycles after the request; bytes A0..A3 with one valid bubble.
  - Response: exactly 4 stack bytes A0..A3, `app_tx_data_length` = 4, `cl_done[0]` 1 cycle after A3, then 16 gap cycles.
- **Simultaneous requests:**
  - Stimulus: `cl_req` = 11 for 3 packets of length 2.
  - Response with RR: grant order 0, 1, 0.
  - Response without RR: grant order 0, 0, 0 while channel 0 keeps requesting.
- **Ack timeout:**
  - Stimulus: `ACK_TIMEOUT` = 8, never ack.
  - Response: `app_tx_request` high for 8 cycles, then `cl_err` pulse, GAP, and re-request.
- **Bad length:**
  - Stimulus: len = 0, then len = 1473.
  - Response: `cl_err` each time, `app_tx_request` never asserted.
- **Stack not ready:**
  - Stimulus: `udp2app_tx_ready` = 0 for 50 cycles with `cl_req` = 10.
  - Response: no request until ready rises, then request 1 cycle later.
- **Reset mid-DATA:**
  - Stimulus: `rst_n` pulled low after byte 2 of 10.
  - Response: all outputs 0 asynchronously, no `cl_done`, clean packet after release.

Source files
------------

// File: rtl/udp_tx_arbiter_pkg.sv
// Shared types and defaults for the two-client UDP TX arbiter.
package udp_tx_arb_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StData,
        StGap
    } state_e;

    localparam int unsigned CH_VIDEO = 0;
    localparam int unsigned CH_CTRL  = 1;

    localparam int unsigned MAX_LEN_DEF     = 1472;
    localparam int unsigned ACK_TIMEOUT_DEF = 4096;
    localparam int unsigned GAP_CYCLES_DEF  = 16;

    function automatic logic [1:0] ch_onehot(input logic ch);
        return ch ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/udp_tx_arbiter_if.sv
// Client-side and stack-side signals of the UDP TX arbiter.
// The master modport drives clients and the stack; the slave modport is the arbiter.
interface udp_tx_arbiter_if;

    logic [1:0]  cl_req;
    logic [15:0] cl_len0;
    logic [15:0] cl_len1;
    logic [15:0] cl_port0;
    logic [15:0] cl_port1;
    logic [7:0]  cl_data0;
    logic [7:0]  cl_data1;
    logic [1:0]  cl_valid;
    logic [1:0]  cl_gnt;
    logic [1:0]  cl_done;
    logic [1:0]  cl_err;
    logic        udp2app_tx_ready;
    logic        udp2app_tx_ack;
    logic        app_tx_request;
    logic        app_tx_data_valid;
    logic [7:0]  app_tx_data;
    logic [15:0] app_tx_data_length;
    logic [15:0] app_tx_dst_port;

    modport master (
        output cl_req, cl_len0, cl_len1, cl_port0, cl_port1, cl_data0, cl_data1, cl_valid,
        output udp2app_tx_ready, udp2app_tx_ack,
        input  cl_gnt, cl_done, cl_err,
        input  app_tx_request, app_tx_data_valid, app_tx_data, app_tx_data_length,
        input  app_tx_dst_port
    );

    modport slave (
        input  cl_req, cl_len0, cl_len1, cl_port0, cl_port1, cl_data0, cl_data1, cl_valid,
        input  udp2app_tx_ready, udp2app_tx_ack,
        output cl_gnt, cl_done, cl_err,
        output app_tx_request, app_tx_data_valid, app_tx_data, app_tx_data_length,
        output app_tx_dst_port
    );

endinterface

// File: rtl/udp_tx_arb_pick.sv
// Combinational winner select. Define UDP_TX_ARB_RR_EN for round-robin;
// otherwise channel 0 (video) has fixed priority.
module udp_tx_arb_pick
    import udp_tx_arb_pkg::*;
(
    input  logic [1:0] i_req,
    input  logic       i_last,
    output logic       o_win
);

`ifdef UDP_TX_ARB_RR_EN
    always_comb begin
        o_win = 1'(CH_VIDEO);
        if (i_req == 2'b11) begin
            o_win = ~i_last;
        end else if (i_req[CH_CTRL]) begin
            o_win = 1'(CH_CTRL);
        end
    end
`else
    // Fixed priority ignores the grant history.
    logic w_unused_last;
    assign w_unused_last = i_last;

    always_comb begin
        o_win = 1'(CH_VIDEO);
        if (!i_req[CH_VIDEO] && i_req[CH_CTRL]) begin
            o_win = 1'(CH_CTRL);
        end
    end
`endif

endmodule

// File: rtl/udp_tx_arbiter.sv
// Two-client UDP TX arbiter: grant, stack request/ack, byte mux and inter-packet gap.
// Selection policy is set by UDP_TX_ARB_RR_EN inside udp_tx_arb_pick.
module udp_tx_arbiter
    import udp_tx_arb_pkg::*;
#(
    parameter int unsigned ACK_TIMEOUT = ACK_TIMEOUT_DEF,
    parameter int unsigned GAP_CYCLES  = GAP_CYCLES_DEF,
    parameter int unsigned MAX_LEN     = MAX_LEN_DEF
) (
    input  logic             udp_clk,
    input  logic             rst_n,
    udp_tx_arbiter_if.slave  bus
);

    localparam int unsigned TO_W  = $clog2(ACK_TIMEOUT) + 1;
    localparam int unsigned GAP_W = $clog2(GAP_CYCLES) + 1;

    state_e            r_state;
    state_e            w_state_next;
    logic              r_last;
    logic              r_win;
    logic [15:0]       r_len;
    logic [15:0]       r_port;
    logic [15:0]       r_byte_cnt;
    logic [TO_W-1:0]   r_to_cnt;
    logic [GAP_W-1:0]  r_gap_cnt;
    logic [1:0]        r_done;
    logic [1:0]        r_err;

    logic              w_pick;
    logic [15:0]       w_sel_len;
    logic [15:0]       w_sel_port;
    logic              w_start;
    logic              w_bad_len;
    logic              w_ack;
    logic              w_ack_timeout;
    logic              w_gap_end;
    logic              w_byte_valid;
    logic [7:0]        w_byte;
    logic              w_last_byte;

    udp_tx_arb_pick u_pick (
        .i_req  (bus.cl_req),
        .i_last (r_last),
        .o_win  (w_pick)
    );

    assign w_sel_len     = w_pick ? bus.cl_len1 : bus.cl_len0;
    assign w_sel_port    = w_pick ? bus.cl_port1 : bus.cl_port0;
    assign w_start       = (r_state == StIdle) && bus.udp2app_tx_ready && (bus.cl_req != 2'b00);
    assign w_bad_len     = (w_sel_len == 16'd0) || (w_sel_len > 16'(MAX_LEN));
    assign w_ack         = (r_state == StReq) && bus.udp2app_tx_ack;
    assign w_ack_timeout = (r_state == StReq) && !bus.udp2app_tx_ack &&
                           (r_to_cnt == TO_W'(ACK_TIMEOUT - 1));
    assign w_gap_end     = (r_gap_cnt == GAP_W'(GAP_CYCLES - 1));
    assign w_byte_valid  = r_win ? bus.cl_valid[1] : bus.cl_valid[0];
    assign w_byte        = r_win ? bus.cl_data1 : bus.cl_data0;
    assign w_last_byte   = (r_state == StData) && w_byte_valid &&
                           (r_byte_cnt == r_len - 16'd1);

    always_ff @(posedge udp_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle: begin
                if (w_start) begin
                    w_state_next = w_bad_len ? StGap : StReq;
                end
            end
            StReq: begin
                if (w_ack) begin
                    w_state_next = StData;
                end else if (w_ack_timeout) begin
                    w_state_next = StGap;
                end
            end
            StData: begin
                if (w_last_byte) begin
                    w_state_next = StGap;
                end
            end
            StGap: begin
                if (w_gap_end) begin
                    w_state_next = StIdle;
                end
            end
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge udp_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last     <= 1'b1;
            r_win      <= 1'b0;
            r_len      <= '0;
            r_port     <= '0;
            r_byte_cnt <= '0;
            r_to_cnt   <= '0;
            r_gap_cnt  <= '0;
            r_done     <= '0;
            r_err      <= '0;
        end else begin
            // Grants that end in a length error still update the history.
            if (w_start) begin
                r_win  <= w_pick;
                r_last <= w_pick;
                r_len  <= w_sel_len;
                r_port <= w_sel_port;
            end
            r_to_cnt  <= (r_state == StReq) ? r_to_cnt + TO_W'(1) : '0;
            r_gap_cnt <= (r_state == StGap) ? r_gap_cnt + GAP_W'(1) : '0;
            if (w_ack) begin
                r_byte_cnt <= '0;
            end else if ((r_state == StData) && w_byte_valid) begin
                r_byte_cnt <= r_byte_cnt + 16'd1;
            end
            r_done <= w_last_byte ? ch_onehot(r_win) : 2'b00;
            r_err  <= ((w_start && w_bad_len) ? ch_onehot(w_pick) : 2'b00) |
                      (w_ack_timeout ? ch_onehot(r_win) : 2'b00);
        end
    end

    always_comb begin
        bus.app_tx_request     = (r_state == StReq);
        bus.cl_gnt             = (r_state == StData) ? ch_onehot(r_win) : 2'b00;
        bus.app_tx_data_valid  = (r_state == StData) && w_byte_valid;
        bus.app_tx_data        = (r_state == StData) ? w_byte : 8'd0;
        bus.cl_done            = r_done;
        bus.cl_err             = r_err;
        bus.app_tx_data_length = r_len;
        bus.app_tx_dst_port    = r_port;
    end

endmodule

// File: tb/tb_udp_tx_arbiter.sv
// Directed bench for udp_tx_arbiter (ACK_TIMEOUT=8, GAP_CYCLES=16).
// Grant order expectations follow UDP_TX_ARB_RR_EN.
module tb_udp_tx_arbiter;

`ifdef UDP_TX_ARB_RR_EN
    localparam int SECOND_CH = 1;
`else
    localparam int SECOND_CH = 0;
`endif

    logic udp_clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    logic saw_req;

    udp_tx_arbiter_if bus ();

    udp_tx_arbiter #(
        .ACK_TIMEOUT (8),
        .GAP_CYCLES  (16),
        .MAX_LEN     (1472)
    ) dut (
        .udp_clk (udp_clk),
        .rst_n   (rst_n),
        .bus     (bus)
    );

    always #5 udp_clk = ~udp_clk;

    task automatic tick();
        @(posedge udp_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Wait for a request, ack it, check the grant, stream n bytes and check cl_done.
    task automatic run_pkt(input int ch, input int n, input logic [7:0] base);
        int k = 0;
        while (!bus.app_tx_request && k < 40) begin
            tick();
            k++;
        end
        chk("req_seen", 32'(bus.app_tx_request), 32'd1);
        bus.udp2app_tx_ack = 1'b1;
        tick();
        bus.udp2app_tx_ack = 1'b0;
        chk("gnt", 32'(bus.cl_gnt), 32'(1 << ch));
        for (int i = 0; i < n; i++) begin
            bus.cl_valid = 2'(1 << ch);
            if (ch == 0) bus.cl_data0 = base + 8'(i);
            else         bus.cl_data1 = base + 8'(i);
            tick();
        end
        bus.cl_valid = 2'b00;
        chk("done", 32'(bus.cl_done), 32'(1 << ch));
    endtask

    task automatic drive_byte(input logic [7:0] b);
        bus.cl_valid = 2'b01;
        bus.cl_data0 = b;
        #1;
        chk("byte_valid", 32'(bus.app_tx_data_valid), 32'd1);
        chk("byte_data", 32'(bus.app_tx_data), 32'(b));
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n                = 1'b0;
        bus.cl_req           = 2'b00;
        bus.cl_len0          = '0;
        bus.cl_len1          = '0;
        bus.cl_port0         = '0;
        bus.cl_port1         = '0;
        bus.cl_data0         = '0;
        bus.cl_data1         = '0;
        bus.cl_valid         = 2'b00;
        bus.udp2app_tx_ready = 1'b1;
        bus.udp2app_tx_ack   = 1'b0;
        #12;
        chk("rst_request", 32'(bus.app_tx_request), 32'd0);
        chk("rst_valid", 32'(bus.app_tx_data_valid), 32'd0);
        chk("rst_gnt", 32'(bus.cl_gnt), 32'd0);
        chk("rst_done", 32'(bus.cl_done), 32'd0);
        chk("rst_err", 32'(bus.cl_err), 32'd0);
        chk("rst_data", 32'(bus.app_tx_data), 32'd0);
        chk("rst_len", 32'(bus.app_tx_data_length), 32'd0);
        chk("rst_port", 32'(bus.app_tx_dst_port), 32'd0);
        rst_n = 1'b1;
        tick();

        // Single video packet, ack after 3 cycles, one bubble with noise on channel 1
        bus.cl_len0  = 16'd4;
        bus.cl_port0 = 16'd8080;
        bus.cl_req   = 2'b01;
        tick();
        chk("t1_request", 32'(bus.app_tx_request), 32'd1);
        chk("t1_len", 32'(bus.app_tx_data_length), 32'd4);
        chk("t1_port", 32'(bus.app_tx_dst_port), 32'd8080);
        tick();
        tick();
        chk("t1_req_hold", 32'(bus.app_tx_request), 32'd1);
        bus.udp2app_tx_ack = 1'b1;
        tick();
        bus.udp2app_tx_ack = 1'b0;
        chk("t1_gnt", 32'(bus.cl_gnt), 32'd1);
        chk("t1_req_drop", 32'(bus.app_tx_request), 32'd0);
        drive_byte(8'hA0);
        drive_byte(8'hA1);
        bus.cl_valid = 2'b10;
        bus.cl_data1 = 8'hFF;
        #1;
        chk("t1_bubble", 32'(bus.app_tx_data_valid), 32'd0);
        chk("t1_no_early_done", 32'(bus.cl_done), 32'd0);
        tick();
        drive_byte(8'hA2);
        drive_byte(8'hA3);
        chk("t1_done", 32'(bus.cl_done), 32'd1);
        chk("t1_gnt_off", 32'(bus.cl_gnt), 32'd0);
        chk("t1_valid_off", 32'(bus.app_tx_data_valid), 32'd0);
        bus.cl_valid = 2'b00;
        tick();
        chk("t1_done_pulse", 32'(bus.cl_done), 32'd0);
        for (int i = 2; i <= 16; i++) begin
            tick();
            chk("t1_gap", 32'(bus.app_tx_request), 32'd0);
        end
        tick();
        chk("t2_request", 32'(bus.app_tx_request), 32'd1);

        // Ack timeout: request high for 8 cycles, then error, gap, re-request
        for (int i = 0; i < 7; i++) begin
            tick();
            chk("t2_req_high", 32'(bus.app_tx_request), 32'd1);
        end
        tick();
        chk("t2_req_low", 32'(bus.app_tx_request), 32'd0);
        chk("t2_err", 32'(bus.cl_err), 32'd1);
        tick();
        chk("t2_err_pulse", 32'(bus.cl_err), 32'd0);
        repeat (15) tick();
        chk("t2_gap", 32'(bus.app_tx_request), 32'd0);
        tick();
        chk("t2_rerequest", 32'(bus.app_tx_request), 32'd1);
        run_pkt(0, 4, 8'hB0);

        // Bad lengths: 0 then MAX_LEN+1, no request may reach the stack
        bus.cl_len0 = 16'd0;
        saw_req = 1'b0;
        for (int k = 0; k < 40 && bus.cl_err == 2'b00; k++) begin
            tick();
            if (bus.app_tx_request) saw_req = 1'b1;
        end
        chk("t3_err_len0", 32'(bus.cl_err), 32'd1);
        chk("t3_noreq_len0", 32'(saw_req), 32'd0);
        bus.cl_len0 = 16'd1473;
        tick();
        for (int k = 0; k < 40 && bus.cl_err == 2'b00; k++) begin
            tick();
            if (bus.app_tx_request) saw_req = 1'b1;
        end
        chk("t3_err_len1473", 32'(bus.cl_err), 32'd1);
        chk("t3_noreq_len1473", 32'(saw_req), 32'd0);
        bus.cl_req = 2'b00;

        // Stack not ready for 50 cycles with control channel requesting
        bus.udp2app_tx_ready = 1'b0;
        bus.cl_req   = 2'b10;
        bus.cl_len1  = 16'd2;
        bus.cl_port1 = 16'd53;
        saw_req = 1'b0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (bus.app_tx_request) saw_req = 1'b1;
        end
        chk("t4_noreq", 32'(saw_req), 32'd0);
        bus.udp2app_tx_ready = 1'b1;
        tick();
        chk("t4_request", 32'(bus.app_tx_request), 32'd1);
        chk("t4_port", 32'(bus.app_tx_dst_port), 32'd53);
        run_pkt(1, 2, 8'hC0);

        // Simultaneous requests, three packets of length 2
        bus.cl_len0 = 16'd2;
        bus.cl_len1 = 16'd2;
        bus.cl_req  = 2'b11;
        run_pkt(0, 2, 8'h10);
        run_pkt(SECOND_CH, 2, 8'h20);
        run_pkt(0, 2, 8'h30);
        bus.cl_req = 2'b00;

        // Reset mid-DATA after byte 2 of 10
        bus.cl_len0 = 16'd10;
        bus.cl_req  = 2'b01;
        for (int k = 0; k < 40 && !bus.app_tx_request; k++) tick();
        chk("t5_request", 32'(bus.app_tx_request), 32'd1);
        bus.udp2app_tx_ack = 1'b1;
        tick();
        bus.udp2app_tx_ack = 1'b0;
        drive_byte(8'h01);
        drive_byte(8'h02);
        bus.cl_valid = 2'b01;
        bus.cl_data0 = 8'h03;
        #1;
        rst_n = 1'b0;
        #1;
        chk("t5_rst_request", 32'(bus.app_tx_request), 32'd0);
        chk("t5_rst_valid", 32'(bus.app_tx_data_valid), 32'd0);
        chk("t5_rst_gnt", 32'(bus.cl_gnt), 32'd0);
        chk("t5_rst_data", 32'(bus.app_tx_data), 32'd0);
        chk("t5_rst_len", 32'(bus.app_tx_data_length), 32'd0);
        chk("t5_rst_port", 32'(bus.app_tx_dst_port), 32'd0);
        tick();
        chk("t5_rst_done", 32'(bus.cl_done), 32'd0);
        bus.cl_valid = 2'b00;
        tick();
        rst_n = 1'b1;
        bus.cl_len0 = 16'd3;
        run_pkt(0, 3, 8'hD0);
        chk("t5_len_after", 32'(bus.app_tx_data_length), 32'd3);
        bus.cl_req = 2'b00;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
